// File: rtl/ext_int_ctrl_pkg.sv
// Shared constants for the external interrupt controller: write opcodes,
// status-word field positions and the status packing helper.
package ext_int_ctrl_pkg;

    localparam int EIC_NUM_SRC = 2;

    localparam logic [1:0] EIC_OP_CLEAR = 2'b00;
    localparam logic [1:0] EIC_OP_MASK  = 2'b01;
    localparam logic [1:0] EIC_OP_MODE  = 2'b10;
    localparam logic [1:0] EIC_OP_SWSET = 2'b11;

    localparam int EIC_ST_REQ     = 31;
    localparam int EIC_ST_ID      = 8;
    localparam int EIC_ST_MODE    = 6;
    localparam int EIC_ST_MASK    = 4;
    localparam int EIC_ST_PENDING = 2;
    localparam int EIC_ST_SYNC    = 0;

    function automatic logic [31:0] eic_status(
        input logic       req,
        input logic       id,
        input logic [1:0] mode,
        input logic [1:0] mask,
        input logic [1:0] pending,
        input logic [1:0] sync
    );
        logic [31:0] word;
        word = 32'h0000_0000;
        word[EIC_ST_REQ]                 = req;
        word[EIC_ST_ID]                  = id;
        word[EIC_ST_MODE+1:EIC_ST_MODE]  = mode;
        word[EIC_ST_MASK+1:EIC_ST_MASK]  = mask;
        word[EIC_ST_PENDING+1:EIC_ST_PENDING] = pending;
        word[EIC_ST_SYNC+1:EIC_ST_SYNC]  = sync;
        return word;
    endfunction

endpackage

// File: rtl/ext_int_ctrl_sync_edge.sv
// One interrupt source: multi-flop synchronizer, previous-value flop and
// mode-selected event (rising edge or level).
module int_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic src,
    input  logic mode,
    output logic sync,
    output logic evt
);

    logic [SYNC_STAGES-1:0] chain_r;
    logic                   prev_r;

    // Synchronizer chain and last synchronized value
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain_r <= '0;
            prev_r  <= 1'b0;
        end else begin
            chain_r <= {chain_r[SYNC_STAGES-2:0], src};
            prev_r  <= chain_r[SYNC_STAGES-1];
        end
    end

    assign sync = chain_r[SYNC_STAGES-1];

    // Level mode passes the synchronized input; edge mode needs a low-to-high step
    always_comb begin
        evt = 1'b0;
        if (mode) begin
            evt = sync;
        end else begin
            evt = sync & ~prev_r;
        end
    end

endmodule

// File: rtl/ext_int_ctrl.sv
// External interrupt controller: latches pending sources, applies mask and
// fixed priority, and serves a single status/command IO register.
module ext_int_ctrl
    import ext_int_ctrl_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [1:0]  IRQ_Src,
    input  logic        IO_EnR,
    input  logic        IO_EnW,
    input  logic [31:0] IO_DataW,
    output logic [31:0] IO_DataR,
    output logic        EIC_I_Req,
    output logic        EIC_I_Id
);

    logic [EIC_NUM_SRC-1:0] sync_s;
    logic [EIC_NUM_SRC-1:0] evt_s;
    logic [EIC_NUM_SRC-1:0] pending_r, pending_next_s;
    logic [EIC_NUM_SRC-1:0] mask_r, mask_next_s;
    logic [EIC_NUM_SRC-1:0] mode_r, mode_next_s;
    logic [1:0]             op_s;
    logic [1:0]             operand_s;
    logic                   req_r, req_next_s;
    logic                   id_r, id_next_s;
    logic [31:0]            data_r;
    logic                   unused_dataw_s;

    for (genvar i = 0; i < EIC_NUM_SRC; i++) begin : g_src
        int_sync_edge #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_sync (
            .clk  (Clock),
            .rst  (Reset),
            .src  (IRQ_Src[i]),
            .mode (mode_r[i]),
            .sync (sync_s[i]),
            .evt  (evt_s[i])
        );
    end

    assign op_s           = IO_DataW[31:30];
    assign operand_s      = IO_DataW[1:0];
    assign unused_dataw_s = ^IO_DataW[29:2];

    // Command decode and next-state: set beats clear, request uses next-state values
    always_comb begin
        pending_next_s = pending_r;
        mask_next_s    = mask_r;
        mode_next_s    = mode_r;
        req_next_s     = 1'b0;
        id_next_s      = id_r;
        for (int i = 0; i < EIC_NUM_SRC; i++) begin
            if (evt_s[i] || (IO_EnW && (op_s == EIC_OP_SWSET) && operand_s[i])) begin
                pending_next_s[i] = 1'b1;
            end else if (IO_EnW && (op_s == EIC_OP_CLEAR) && operand_s[i]) begin
                pending_next_s[i] = 1'b0;
            end else begin
                pending_next_s[i] = pending_r[i];
            end
        end
        if (IO_EnW) begin
            case (op_s)
                EIC_OP_MASK: mask_next_s = operand_s;
                EIC_OP_MODE: mode_next_s = operand_s;
                default:     mask_next_s = mask_r;
            endcase
        end else begin
            mask_next_s = mask_r;
        end
        req_next_s = |(pending_next_s & mask_next_s);
        if (req_next_s) begin
            id_next_s = (pending_next_s[0] & mask_next_s[0]) ? 1'b0 : 1'b1;
        end else begin
            id_next_s = id_r;
        end
    end

    // Control state, registered request/ID and registered read data
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            pending_r <= '0;
            mask_r    <= '0;
            mode_r    <= '0;
            req_r     <= 1'b0;
            id_r      <= 1'b0;
            data_r    <= 32'h0000_0000;
        end else begin
            pending_r <= pending_next_s;
            mask_r    <= mask_next_s;
            mode_r    <= mode_next_s;
            req_r     <= req_next_s;
            id_r      <= id_next_s;
            if (IO_EnR) begin
                data_r <= eic_status(req_next_s, id_next_s, mode_r, mask_r, pending_r, sync_s);
            end else begin
                data_r <= data_r;
            end
        end
    end

    assign IO_DataR  = data_r;
    assign EIC_I_Req = req_r;
    assign EIC_I_Id  = id_r;

endmodule

// File: tb/tb_ext_int_ctrl.sv
// Directed self-checking bench for ext_int_ctrl with hand-computed expectations.
module tb_ext_int_ctrl;

    logic        Clock;
    logic        Reset;
    logic [1:0]  IRQ_Src;
    logic        IO_EnR;
    logic        IO_EnW;
    logic [31:0] IO_DataW;
    logic [31:0] IO_DataR;
    logic        EIC_I_Req;
    logic        EIC_I_Id;

    int n_checks = 0;
    int n_fail   = 0;

    ext_int_ctrl #(
        .SYNC_STAGES (2)
    ) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .IRQ_Src   (IRQ_Src),
        .IO_EnR    (IO_EnR),
        .IO_EnW    (IO_EnW),
        .IO_DataW  (IO_DataW),
        .IO_DataR  (IO_DataR),
        .EIC_I_Req (EIC_I_Req),
        .EIC_I_Id  (EIC_I_Id)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic io_write(input logic [31:0] data);
        IO_EnW   = 1'b1;
        IO_DataW = data;
        tick();
        IO_EnW   = 1'b0;
        IO_DataW = 32'h0000_0000;
    endtask

    task automatic io_read();
        IO_EnR = 1'b1;
        tick();
        IO_EnR = 1'b0;
    endtask

    initial begin
        Reset    = 1'b1;
        IRQ_Src  = 2'b00;
        IO_EnR   = 1'b0;
        IO_EnW   = 1'b0;
        IO_DataW = 32'h0000_0000;
        #3;
        chk("reset_req", {31'd0, EIC_I_Req}, 32'd0);
        chk("reset_id", {31'd0, EIC_I_Id}, 32'd0);
        chk("reset_datar", IO_DataR, 32'h0000_0000);
        tick();
        tick();
        Reset = 1'b0;
        tick();

        // 1: mask both, pulse source 1
        io_write(32'h4000_0003);
        chk("mask_no_req", {31'd0, EIC_I_Req}, 32'd0);
        IRQ_Src = 2'b10;
        tick();
        chk("lat_edge0", {31'd0, EIC_I_Req}, 32'd0);
        tick();
        chk("lat_edge1", {31'd0, EIC_I_Req}, 32'd0);
        tick();
        chk("lat_edge2_req", {31'd0, EIC_I_Req}, 32'd1);
        chk("lat_edge2_id", {31'd0, EIC_I_Id}, 32'd1);
        tick();
        IRQ_Src = 2'b00;
        repeat (4) tick();
        io_read();
        chk("read_status1", IO_DataR, 32'h8000_0138);

        // 2: priority and acknowledge
        io_write(32'hC000_0001);
        chk("both_id0", {31'd0, EIC_I_Id}, 32'd0);
        chk("both_req", {31'd0, EIC_I_Req}, 32'd1);
        io_write(32'h0000_0001);
        chk("clr0_id1", {31'd0, EIC_I_Id}, 32'd1);
        chk("clr0_req", {31'd0, EIC_I_Req}, 32'd1);
        io_write(32'h0000_0002);
        chk("clr1_req0", {31'd0, EIC_I_Req}, 32'd0);
        chk("clr1_id_hold", {31'd0, EIC_I_Id}, 32'd1);

        // 3: clear collides with a new edge on source 0
        IRQ_Src = 2'b01;
        tick();
        tick();
        io_write(32'h0000_0001);
        chk("collide_req", {31'd0, EIC_I_Req}, 32'd1);
        chk("collide_id", {31'd0, EIC_I_Id}, 32'd0);
        IRQ_Src = 2'b00;
        repeat (3) tick();
        chk("collide_held", {31'd0, EIC_I_Req}, 32'd1);
        io_write(32'h0000_0001);
        chk("collide_clr", {31'd0, EIC_I_Req}, 32'd0);
        repeat (2) tick();

        // 4: level mode on source 0
        io_write(32'h8000_0001);
        IRQ_Src = 2'b01;
        repeat (3) tick();
        chk("level_req", {31'd0, EIC_I_Req}, 32'd1);
        io_write(32'h0000_0001);
        chk("level_clr_held", {31'd0, EIC_I_Req}, 32'd1);
        tick();
        chk("level_still", {31'd0, EIC_I_Req}, 32'd1);
        IRQ_Src = 2'b00;
        repeat (3) tick();
        io_write(32'h0000_0001);
        chk("level_low_clr", {31'd0, EIC_I_Req}, 32'd0);
        io_write(32'h8000_0000);

        // 5: masked software set, then unmask
        io_write(32'h4000_0000);
        io_write(32'hC000_0002);
        chk("swset_masked", {31'd0, EIC_I_Req}, 32'd0);
        io_read();
        chk("swset_status", IO_DataR, 32'h0000_0008);
        io_write(32'h4000_0002);
        chk("unmask_req", {31'd0, EIC_I_Req}, 32'd1);
        chk("unmask_id", {31'd0, EIC_I_Id}, 32'd1);
        io_read();
        chk("unmask_status", IO_DataR, 32'h8000_0128);

        // 6: asynchronous reset mid-cycle
        #2;
        Reset = 1'b1;
        #1;
        chk("arst_req", {31'd0, EIC_I_Req}, 32'd0);
        chk("arst_id", {31'd0, EIC_I_Id}, 32'd0);
        chk("arst_datar", IO_DataR, 32'h0000_0000);
        tick();
        Reset = 1'b0;
        tick();
        IRQ_Src = 2'b10;
        repeat (5) tick();
        chk("post_rst_masked", {31'd0, EIC_I_Req}, 32'd0);
        io_read();
        chk("post_rst_status", IO_DataR, 32'h0000_000A);
        IRQ_Src = 2'b00;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
